// File: rtl/calc1_pkg.sv
// calc1_pkg: shared widths, command/response codes and slot states for the
// calc1 port scheduler and its ALU.
package calc1_pkg;

  localparam int DATA_W    = 32;
  localparam int CMD_W     = 4;
  localparam int RESP_W    = 2;
  localparam int NUM_PORTS = 4;

  localparam logic [CMD_W-1:0] CMD_NOP = 4'd0;
  localparam logic [CMD_W-1:0] CMD_ADD = 4'd1;
  localparam logic [CMD_W-1:0] CMD_SUB = 4'd2;
  localparam logic [CMD_W-1:0] CMD_SHL = 4'd5;
  localparam logic [CMD_W-1:0] CMD_SHR = 4'd6;

  localparam logic [RESP_W-1:0] RESP_NONE = 2'd0;
  localparam logic [RESP_W-1:0] RESP_OK   = 2'd1;
  localparam logic [RESP_W-1:0] RESP_ERR  = 2'd2;

  typedef enum logic [1:0] {
    SLOT_EMPTY = 2'd0,
    SLOT_OP1   = 2'd1,
    SLOT_READY = 2'd2
  } slot_state_t;

endpackage

// File: rtl/calc1_alu.sv
// calc1_alu: combinational add/sub/shift with error checks. The result is
// captured on the edge where a dispatch is valid and reads zero otherwise,
// so every response lasts exactly one cycle.
module calc1_alu
  import calc1_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  input  logic [CMD_W-1:0]  cmd,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  output logic [RESP_W-1:0] resp,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W:0]   sum;
  logic [4:0]        shamt;
  logic [RESP_W-1:0] resp_next;
  logic [DATA_W-1:0] data_next;

  // Compute the response for the dispatched command; unknown commands are errors
  always_comb begin
    sum       = {1'b0, op1} + {1'b0, op2};
    shamt     = op2[4:0];
    resp_next = RESP_ERR;
    data_next = '0;
    case (cmd)
      CMD_ADD: begin
        if (!sum[DATA_W]) begin
          resp_next = RESP_OK;
          data_next = sum[DATA_W-1:0];
        end
      end
      CMD_SUB: begin
        if (op2 <= op1) begin
          resp_next = RESP_OK;
          data_next = op1 - op2;
        end
      end
      CMD_SHL: begin
        resp_next = RESP_OK;
        data_next = op1 << shamt;
      end
      CMD_SHR: begin
        resp_next = RESP_OK;
        data_next = op1 >> shamt;
      end
      default: begin
        resp_next = RESP_ERR;
        data_next = '0;
      end
    endcase
  end

  // Register the result only on a dispatch edge, otherwise return to idle
  always_ff @(posedge clk) begin
    if (!reset) begin
      resp <= RESP_NONE;
      data <= '0;
    end else if (valid) begin
      resp <= resp_next;
      data <= data_next;
    end else begin
      resp <= RESP_NONE;
      data <= '0;
    end
  end

endmodule

// File: rtl/calc1_port_scheduler.sv
// calc1_port_scheduler: four two-cycle request slots, a round-robin arbiter
// feeding one shared calc1_alu, and routing of each one-cycle response back
// to the port that issued it.
module calc1_port_scheduler
  import calc1_pkg::*;
(
  input  logic              c_clk,
  input  logic              reset,
  input  logic [CMD_W-1:0]  req1_cmd_in,
  input  logic [CMD_W-1:0]  req2_cmd_in,
  input  logic [CMD_W-1:0]  req3_cmd_in,
  input  logic [CMD_W-1:0]  req4_cmd_in,
  input  logic [DATA_W-1:0] req1_data_in,
  input  logic [DATA_W-1:0] req2_data_in,
  input  logic [DATA_W-1:0] req3_data_in,
  input  logic [DATA_W-1:0] req4_data_in,
  output logic [DATA_W-1:0] out_data1,
  output logic [DATA_W-1:0] out_data2,
  output logic [DATA_W-1:0] out_data3,
  output logic [DATA_W-1:0] out_data4,
  output logic [RESP_W-1:0] out_resp1,
  output logic [RESP_W-1:0] out_resp2,
  output logic [RESP_W-1:0] out_resp3,
  output logic [RESP_W-1:0] out_resp4
);

  logic [CMD_W-1:0]  cmd_in  [NUM_PORTS];
  logic [DATA_W-1:0] data_in [NUM_PORTS];

  slot_state_t       state_q [NUM_PORTS];
  slot_state_t       state_d [NUM_PORTS];
  logic [CMD_W-1:0]  cmd_q   [NUM_PORTS];
  logic [DATA_W-1:0] op1_q   [NUM_PORTS];
  logic [DATA_W-1:0] op2_q   [NUM_PORTS];

  logic [1:0]        ptr_q;
  logic [1:0]        port_q;
  logic              grant_valid;
  logic [1:0]        grant_idx;
  logic [1:0]        scan_idx;

  logic [RESP_W-1:0] alu_resp;
  logic [DATA_W-1:0] alu_data;

  assign cmd_in[0]  = req1_cmd_in;
  assign cmd_in[1]  = req2_cmd_in;
  assign cmd_in[2]  = req3_cmd_in;
  assign cmd_in[3]  = req4_cmd_in;
  assign data_in[0] = req1_data_in;
  assign data_in[1] = req2_data_in;
  assign data_in[2] = req3_data_in;
  assign data_in[3] = req4_data_in;

  // Slot state register; reset discards any captured or pending work
  always_ff @(posedge c_clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!reset) state_q[i] <= SLOT_EMPTY;
      else        state_q[i] <= state_d[i];
    end
  end

  // Slot transitions; commands arriving while a slot is busy are simply ignored
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        SLOT_EMPTY: if (cmd_in[i] != CMD_NOP) state_d[i] = SLOT_OP1;
        SLOT_OP1:   state_d[i] = SLOT_READY;
        SLOT_READY: if (grant_valid && grant_idx == 2'(i)) state_d[i] = SLOT_EMPTY;
        default:    state_d[i] = SLOT_EMPTY;
      endcase
    end
  end

  // Capture command/op1 on acceptance and op2 one cycle later; otherwise hold
  always_ff @(posedge c_clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (state_q[i] == SLOT_EMPTY && cmd_in[i] != CMD_NOP) begin
        cmd_q[i] <= cmd_in[i];
        op1_q[i] <= data_in[i];
      end
      if (state_q[i] == SLOT_OP1) begin
        op2_q[i] <= data_in[i];
      end
    end
  end

  // Round-robin search for the first READY slot starting at the pointer
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = ptr_q;
    scan_idx    = ptr_q;
    for (int i = 0; i < NUM_PORTS; i++) begin
      scan_idx = ptr_q + 2'(i);
      if (!grant_valid && state_q[scan_idx] == SLOT_READY) begin
        grant_valid = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  // Advance the pointer past the winner and remember which port owns the result
  always_ff @(posedge c_clk) begin
    if (!reset) begin
      ptr_q  <= 2'd0;
      port_q <= 2'd0;
    end else if (grant_valid) begin
      ptr_q  <= grant_idx + 2'd1;
      port_q <= grant_idx;
    end
  end

  calc1_alu u_alu (
    .clk   (c_clk),
    .reset (reset),
    .valid (grant_valid),
    .cmd   (cmd_q[grant_idx]),
    .op1   (op1_q[grant_idx]),
    .op2   (op2_q[grant_idx]),
    .resp  (alu_resp),
    .data  (alu_data)
  );

  // Steer the registered result to its owning port; every other port reads zero
  always_comb begin
    out_data1 = '0;
    out_data2 = '0;
    out_data3 = '0;
    out_data4 = '0;
    out_resp1 = RESP_NONE;
    out_resp2 = RESP_NONE;
    out_resp3 = RESP_NONE;
    out_resp4 = RESP_NONE;
    case (port_q)
      2'd0: begin out_data1 = alu_data; out_resp1 = alu_resp; end
      2'd1: begin out_data2 = alu_data; out_resp2 = alu_resp; end
      2'd2: begin out_data3 = alu_data; out_resp3 = alu_resp; end
      default: begin out_data4 = alu_data; out_resp4 = alu_resp; end
    endcase
  end

endmodule
